// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHECK state only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int DSIZE          = 32;
  localparam int ISIZE          = 32;
  localparam int BYTES_PER_INST = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd4,
`endif
    DONE  = 3'd3
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and status flags of the loader.
// The loader side uses the slave modport; the host/memory side uses master.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic             start;
  logic [15:0]      word_count;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mem_wen;
  logic [DSIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  start, word_count, in_data, in_valid,
    output in_ready, mem_wen, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

  modport master (
    output start, word_count, in_data, in_valid,
    input  in_ready, mem_wen, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Assembles little-endian bytes into one instruction word; the first byte lands in bits [7:0].
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic [ISIZE-1:0] word_o,
  output logic             last_o
);

  localparam int IDXW = $clog2(BYTES_PER_INST);

  // Only the first three bytes need storing; the fourth is merged combinationally.
  logic [ISIZE-9:0] shift_q, shift_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  assign word_o = {byte_i, shift_q};
  assign last_o = accept_i && (idx_q == IDXW'(BYTES_PER_INST - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (accept_i) begin
      shift_d = word_o[ISIZE-1:8];
      idx_d   = idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads word_count instructions from a byte stream into instruction memory while holding the CPU.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked after the last word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e           state_q, state_d;
  logic [15:0]      wordIdx_q, wordIdx_d;
  logic [15:0]      count_q, count_d;
  logic [DSIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             readyInt, wenInt, doneInt;
  logic             accept, packAccept, lastByte, countOk, startOk, startBad;
  logic [ISIZE-1:0] packedWord;

  assign accept     = bus.in_valid && readyInt;
  assign packAccept = accept && (state_q == RECV);
  assign countOk    = (bus.word_count != 16'd0) && ({1'b0, bus.word_count} <= DEPTH_W);
  assign startOk    = (state_q == IDLE) && bus.start && countOk;
  assign startBad   = (state_q == IDLE) && bus.start && !countOk;

  imem_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (startOk),
    .accept_i (packAccept),
    .byte_i   (bus.in_data),
    .word_o   (packedWord),
    .last_o   (lastByte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (startOk) state_d = RECV;
      RECV:  if (lastByte) state_d = WRITE;
      WRITE: begin
        if (wordIdx_q + 16'd1 == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (accept) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    readyInt = 1'b0;
    wenInt   = 1'b0;
    doneInt  = 1'b0;
    case (state_q)
      RECV:  readyInt = 1'b1;
      WRITE: wenInt   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: readyInt = 1'b1;
`endif
      DONE:  doneInt  = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = readyInt;
  assign bus.mem_wen   = wenInt;
  assign bus.done      = doneInt;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cpu_hold  = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err       = err_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // Address and data are captured with the last byte so they stay stable outside WRITE.
  always_comb begin
    wordIdx_d = wordIdx_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    if (startOk) begin
      wordIdx_d = '0;
      count_d   = bus.word_count;
      err_d     = 1'b0;
    end
    if (startBad) err_d = 1'b1;
    if (lastByte) begin
      addr_d  = DSIZE'(wordIdx_q);
      wdata_d = DSIZE'(packedWord);
    end
    if ((state_q == WRITE) && (state_d == RECV)) wordIdx_d = wordIdx_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    if (startOk) csum_d = 8'h00;
    else if (packAccept) csum_d = csum_q ^ bus.in_data;
    if ((state_q == CHECK) && accept && (bus.in_data != csum_q)) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordIdx_q <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      wordIdx_q <= wordIdx_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; the checksum case runs when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;
  int   doneCount  = 0;
  logic [7:0]  xorAcc;
  logic [31:0] wenAddr[$];
  logic [31:0] wenData[$];

  imem_loader_if bus ();

  imem_loader #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every memory write and done pulse mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (bus.mem_wen) begin
      wenAddr.push_back(bus.mem_addr);
      wenData.push_back(bus.mem_wdata);
    end
    if (bus.done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] count);
    bus.start      = 1'b1;
    bus.word_count = count;
    @(negedge clk);
    bus.start = 1'b0;
    xorAcc    = 8'h00;
  endtask

  // Called at a falling edge; returns at the falling edge just after the byte was taken.
  task automatic sendRaw(input logic [7:0] b, input int gap);
    int budget = 50;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    xorAcc = xorAcc ^ b;
    sendRaw(b, gap);
  endtask

  task automatic waitDone(input string tag);
    int budget = 40;
    while (!bus.done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(tag, {31'd0, bus.done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic finishLoad(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendRaw(xorAcc, 0);
`endif
    waitDone(tag);
  endtask

  task automatic clearLog();
    wenAddr.delete();
    wenData.delete();
    doneCount = 0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.word_count = 16'd0;
    bus.in_data    = 8'h00;
    bus.in_valid   = 1'b0;
    xorAcc         = 8'h00;
    rst            = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_flags", {26'd0, bus.in_ready, bus.mem_wen, bus.cpu_hold, bus.busy, bus.done, bus.err}, 32'd0);
    checkOutput("reset_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single word, back-to-back bytes, exact latency.
    clearLog();
    applyStimulus(16'd1);
    checkOutput("w1_hold", {30'd0, bus.cpu_hold, bus.busy}, 32'd3);
    sendByte(8'h20, 0);
    sendByte(8'h00, 0);
    sendByte(8'h1F, 0);
    sendByte(8'h8B, 0);
    checkOutput("w1_wen", {31'd0, bus.mem_wen}, 32'd1);
    checkOutput("w1_addr", bus.mem_addr, 32'd0);
    checkOutput("w1_wdata", bus.mem_wdata, 32'h8B1F0020);
    checkOutput("w1_ready_low", {31'd0, bus.in_ready}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendRaw(xorAcc, 0);
`else
    @(negedge clk);
`endif
    checkOutput("w1_done", {31'd0, bus.done}, 32'd1);
    checkOutput("w1_hold_in_done", {31'd0, bus.cpu_hold}, 32'd1);
    @(negedge clk);
    checkOutput("w1_after", {29'd0, bus.done, bus.cpu_hold, bus.busy}, 32'd0);
    checkOutput("w1_wdata_hold", bus.mem_wdata, 32'h8B1F0020);
    checkOutput("w1_wen_count", wenAddr.size(), 32'd1);

    // Three words with in_valid toggling.
    clearLog();
    applyStimulus(16'd3);
    sendByte(8'h01, 1); sendByte(8'h02, 1); sendByte(8'h03, 1); sendByte(8'h04, 1);
    sendByte(8'hAA, 1); sendByte(8'hBB, 1); sendByte(8'hCC, 1); sendByte(8'hDD, 1);
    sendByte(8'hFF, 1); sendByte(8'h00, 1); sendByte(8'hFF, 1); sendByte(8'h00, 1);
    finishLoad("w3_done");
    checkOutput("w3_count", wenAddr.size(), 32'd3);
    if (wenAddr.size() == 3) begin
      checkOutput("w3_addr0", wenAddr[0], 32'd0);
      checkOutput("w3_data0", wenData[0], 32'h04030201);
      checkOutput("w3_addr1", wenAddr[1], 32'd1);
      checkOutput("w3_data1", wenData[1], 32'hDDCCBBAA);
      checkOutput("w3_addr2", wenAddr[2], 32'd2);
      checkOutput("w3_data2", wenData[2], 32'h00FF00FF);
    end

    // Illegal counts: zero and DEPTH+1.
    clearLog();
    applyStimulus(16'd0);
    checkOutput("cnt0_flags", {29'd0, bus.err, bus.busy, bus.cpu_hold}, 32'd4);
    applyStimulus(16'd257);
    checkOutput("cnt257_flags", {29'd0, bus.err, bus.busy, bus.cpu_hold}, 32'd4);
    repeat (3) @(negedge clk);
    checkOutput("bad_no_wen", wenAddr.size(), 32'd0);
    checkOutput("bad_no_done", doneCount, 32'd0);
    applyStimulus(16'd256);
    checkOutput("max_clears_err", {30'd0, bus.err, bus.busy}, 32'd1);
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    applyStimulus(16'd1);
    checkOutput("good_err", {31'd0, bus.err}, 32'd0);
    sendByte(8'h78, 0); sendByte(8'h56, 0); sendByte(8'h34, 0); sendByte(8'h12, 0);
    finishLoad("good_done");
    checkOutput("good_wdata", bus.mem_wdata, 32'h12345678);

    // Reset in the middle of a two-word load.
    clearLog();
    applyStimulus(16'd2);
    sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
    sendByte(8'h55, 0); sendByte(8'h66, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_flags", {26'd0, bus.in_ready, bus.mem_wen, bus.cpu_hold, bus.busy, bus.done, bus.err}, 32'd0);
    checkOutput("abort_addr", bus.mem_addr, 32'd0);
    checkOutput("abort_wdata", bus.mem_wdata, 32'd0);
    checkOutput("abort_word0", wenData.size() == 1 ? wenData[0] : 32'hDEAD0000, 32'h44332211);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_done", doneCount, 32'd0);
    applyStimulus(16'd1);
    sendByte(8'hEF, 0); sendByte(8'hBE, 0); sendByte(8'hAD, 0); sendByte(8'hDE, 0);
    finishLoad("reload_done");
    checkOutput("reload_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkOutput("reload_addr", bus.mem_addr, 32'd0);

    // start re-asserted mid-load must be ignored.
    clearLog();
    applyStimulus(16'd2);
    sendByte(8'hA3, 0); sendByte(8'hA2, 0);
    bus.start      = 1'b1;
    bus.word_count = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("restart_busy", {31'd0, bus.busy}, 32'd1);
    sendByte(8'hA1, 0); sendByte(8'hA0, 0);
    sendByte(8'hB3, 0); sendByte(8'hB2, 0); sendByte(8'hB1, 0); sendByte(8'hB0, 0);
    finishLoad("restart_done");
    repeat (10) @(negedge clk);
    checkOutput("restart_wens", wenAddr.size(), 32'd2);
    checkOutput("restart_idle", {30'd0, bus.busy, bus.err}, 32'd0);
    checkOutput("restart_last", bus.mem_wdata, 32'hB0B1B2B3);
    checkOutput("restart_addr", bus.mem_addr, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum byte: correct, then wrong.
    applyStimulus(16'd1);
    sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
    sendRaw(8'h44, 0);
    checkOutput("csum_ok", {30'd0, bus.done, bus.err}, 32'd2);
    @(negedge clk);
    applyStimulus(16'd1);
    sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
    sendRaw(8'h45, 0);
    checkOutput("csum_bad", {30'd0, bus.done, bus.err}, 32'd3);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the maximum number of instruction words loadable.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-005 SHALL have port word_count  input  16  number of 32-bit instructions to load, sampled with start.
REQ-006 SHALL have port in_data  input  8  byte stream from host.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte; transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port mem_wen  output  1  instruction-memory write enable.
REQ-010 SHALL have port mem_addr  output  DSIZE  instruction-memory word address; PC-compatible, step 1.
REQ-011 SHALL have port mem_wdata  output  DSIZE  instruction word, zero-extended from ISIZE.
REQ-012 SHALL have port cpu_hold  output  1  holds pipeline in reset while loading.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE (plus CHECK under REQ-030).
REQ-017 IDLE: in_ready=0, mem_wen=0; start with 1<=word_count<=DEPTH SHALL clear err, zero the word index and byte index, and enter RECV.
REQ-018 IDLE: start with word_count=0 or >DEPTH SHALL set err, stay in IDLE, and assert neither done nor cpu_hold.
REQ-019 RECV: in_ready=1; the k-th accepted byte (k=0..3) SHALL be placed in word bits [8k+7:8k] (little-endian); the 4th accepted byte SHALL move the FSM to WRITE.
REQ-020 WRITE: SHALL last exactly one cycle with mem_wen=1, mem_addr=word index, mem_wdata=assembled word, in_ready=0.
REQ-021 After WRITE, SHALL enter DONE if word index+1==word_count, else return to RECV with word index incremented.
REQ-022 DONE: done=1 for exactly one cycle, then SHALL return to IDLE.
REQ-023 Latency: last byte accepted in cycle N, mem_wen in cycle N+1, done in cycle N+2.
REQ-024 cpu_hold SHALL be high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-025 start while busy SHALL be ignored; in_valid stalls of any length SHALL be tolerated with no byte loss.
REQ-026 mem_addr and mem_wdata SHALL hold their last values when mem_wen=0.

Reset
REQ-027 rst low SHALL immediately force IDLE, with in_ready, mem_wen, mem_addr, mem_wdata, cpu_hold, busy, done, and err all 0.
REQ-028 Reset during a load SHALL abort it with no done pulse; memory words already written SHALL NOT be cleared.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN SHALL select trailing-checksum support.
REQ-030 With the macro defined, after the final WRITE the FSM SHALL enter CHECK, accept one more byte, and compare it to the XOR of all data bytes; a mismatch SHALL set err; done SHALL pulse one cycle after the checksum byte in either case.
REQ-031 With the macro undefined, there SHALL be no CHECK state, no extra byte, and REQ-023 timing applies.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding and BYTES_PER_INST=4; DSIZE and ISIZE SHALL come from the existing shared defines.
REQ-033 Byte assembly (shift register plus byte index) SHALL be a sub-module named imem_byte_packer.

Verification
REQ-034 word_count=1, bytes 0x20,0x00,0x1F,0x8B sent back-to-back -> mem_wen once with addr 0 and wdata 0x8B1F0020; done 2 cycles after last byte; cpu_hold then drops.
REQ-035 word_count=3, in_valid toggling every other cycle -> writes to addr 0,1,2 with correct words; no lost or duplicated bytes.
REQ-036 word_count=0, then word_count=DEPTH+1 -> err=1, busy=0, no mem_wen, no done; a following valid start clears err.
REQ-037 rst pulled low after 6 bytes of a 2-word load -> all outputs 0 at once; word 0 was written; a subsequent load works normally.
REQ-038 start re-asserted mid-load with word_count=5 -> ignored; the original count completes.
REQ-039 With IMEM_LOADER_CHECKSUM_EN, 1 word 0x11,0x22,0x33,0x44 then checksum 0x44 -> err=0; checksum 0x45 -> err=1; done pulses in both cases.
